// File: rtl/debug_tx_pkg.sv
// Shared types and helpers for the debug snapshot byte serializer.
package debug_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } tx_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Bytes on the wire for one frame: optional 3-byte header, payload, optional checksum.
  function automatic int unsigned total_bytes(input int unsigned frame_bytes,
                                              input bit          send_header,
                                              input bit          send_checksum);
    return (send_header ? 32'd3 : 32'd0) + frame_bytes + (send_checksum ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/debug_frame_sel.sv
// Combinational byte selector: maps the issued-byte count to header, payload or checksum byte.
module debug_frame_sel
  import debug_tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 220,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          SEND_HEADER = 1'b1,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned CW          = 8
) (
  input  logic [FRAME_BYTES*8-1:0] frame,
  input  logic [CW-1:0]            cnt,
  input  logic [7:0]               csum,
  output logic [7:0]               byte_c,
  output logic                     payload_c
);

  localparam int unsigned IW  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [15:0] LEN = 16'(FRAME_BYTES);

  logic [31:0]   pos;
  logic [31:0]   rel;
  logic [IW-1:0] idx;

  // Anything past the header and payload is the checksum slot.
  always_comb begin
    pos       = 32'(cnt);
    rel       = SEND_HEADER ? (pos - 32'd3) : pos;
    idx       = '0;
    byte_c    = csum;
    payload_c = 1'b0;
    if (SEND_HEADER && (pos < 32'd3)) begin
      case (pos[1:0])
        2'd0:    byte_c = SYNC_BYTE;
        2'd1:    byte_c = LEN[15:8];
        default: byte_c = LEN[7:0];
      endcase
    end else if (rel < FRAME_BYTES) begin
      payload_c = 1'b1;
      idx       = MSB_FIRST ? IW'(FRAME_BYTES - 32'd1 - rel) : IW'(rel);
      byte_c    = frame[8*idx +: 8];
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Serializes a captured debug snapshot into UART writes, optionally framed with header and checksum.
module debug_frame_tx
  import debug_tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES   = 220,
  parameter bit          MSB_FIRST     = 1'b1,
  parameter bit          SEND_HEADER   = 1'b1,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter bit          SEND_CHECKSUM = 1'b1,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send,
  input  logic [FRAME_BYTES*8-1:0] send_data,
  input  logic                     tx_busy,
  output logic                     wr_uart,
  output logic [7:0]               w_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NB      = total_bytes(FRAME_BYTES, SEND_HEADER, SEND_CHECKSUM);
  localparam int unsigned CW      = $clog2(NB + 1);
  localparam int unsigned GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int unsigned GW      = $clog2(GAP_EFF + 1);
  localparam int unsigned DW      = FRAME_BYTES * 8;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    csum_q, csum_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          wr_d, busy_d, done_d;
  logic [7:0]    wdata_d;
  logic [7:0]    sel_byte_c;
  logic          sel_payload_c;

  debug_frame_sel #(
    .FRAME_BYTES (FRAME_BYTES),
    .MSB_FIRST   (MSB_FIRST),
    .SEND_HEADER (SEND_HEADER),
    .SYNC_BYTE   (SYNC_BYTE),
    .CW          (CW)
  ) u_sel (
    .frame     (shadow_q),
    .cnt       (cnt_q),
    .csum      (csum_q),
    .byte_c    (sel_byte_c),
    .payload_c (sel_payload_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      wr_uart  <= 1'b0;
      w_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      wr_uart  <= wr_d;
      w_data   <= wdata_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and registered-output logic; HOLD ignores tx_busy so strobes never abut.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    wr_d     = 1'b0;
    wdata_d  = w_data;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          shadow_d = send_data;
          csum_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (!tx_busy) begin
          wr_d    = 1'b1;
          wdata_d = sel_byte_c;
          cnt_d   = cnt_q + CW'(1);
          gap_d   = GW'(GAP_EFF);
          if (sel_payload_c) csum_d = csum_q + sel_byte_c;
          state_d = HOLD;
        end
      end
      HOLD: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          state_d = (cnt_q == CW'(NB)) ? DONE : EMIT;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/debug_frame_tx.md
Name: debug_frame_tx

Overview:
Parametrised serializer that sends a wide debug snapshot from the MIPS core to the UART transmitter as a byte stream. It captures the whole frame when a send is accepted. It can optionally wrap the frame with a sync/length header and an 8-bit checksum, and it supports MSB-first or LSB-first byte order. It sits between the debug unit and the UART TX core and paces each write on tx_busy.

Parameters:
FRAME_BYTES, 220, payload size in bytes (send_data width = FRAME_BYTES*8); legal range 1..65535
MSB_FIRST, 1, 1: payload byte FRAME_BYTES-1 is sent first; 0: byte 0 is sent first
SEND_HEADER, 1, 1: prefix the frame with SYNC_BYTE, LEN_HI, LEN_LO
SYNC_BYTE, 8'hA5, first header byte
SEND_CHECKSUM, 1, 1: append the 8-bit modular sum of all payload bytes
GAP_CYCLES, 1, minimum idle cycles after each wr_uart before tx_busy is sampled again (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
send  in  1  start request, sampled in IDLE only
send_data  in  FRAME_BYTES*8  payload; byte k = send_data[8k+7:8k]
tx_busy  in  1  UART TX busy
wr_uart  out  1  registered one-cycle write strobe to the UART
w_data  out  8  registered byte, valid while wr_uart=1
busy  out  1  high from send acceptance until done
done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (reset=0, async): state=IDLE; wr_uart=0, w_data=0, busy=0, done=0; byte counter, gap counter and checksum cleared; shadow register cleared. A reset mid-frame aborts the frame at once, and no further bytes are issued.
- Total bytes per frame: N = 3*SEND_HEADER + FRAME_BYTES + SEND_CHECKSUM. The counter width is clog2(N+1).
- States:
  - IDLE: send=1 at edge E0 → load send_data into the shadow register, clear checksum and counter, busy<=1, go EMIT. send=0 → stay.
  - EMIT: if tx_busy=0 at an edge → wr_uart<=1, w_data<=current byte, counter+1, gap<=GAP_CYCLES, go HOLD. If tx_busy=1 → stay, wr_uart<=0.
  - HOLD: wr_uart<=0. Decrement gap each cycle. When gap reaches 0: if counter==N go DONE, else go EMIT. tx_busy is ignored in HOLD.
  - DONE: done<=1 for one cycle, busy<=0, go IDLE. done clears on the next edge.
- Byte sequence:
  - Header bytes: SYNC_BYTE, FRAME_BYTES[15:8], FRAME_BYTES[7:0].
  - Payload: MSB_FIRST=1 sends byte FRAME_BYTES-1 down to 0; MSB_FIRST=0 sends byte 0 up to FRAME_BYTES-1. Bit order inside each byte is unchanged.
  - Checksum byte last (sum mod 256 of payload bytes only, accumulated as each payload byte is issued).
- Latency: first wr_uart is at E1, one edge after acceptance, when tx_busy=0. Minimum spacing between strobes is GAP_CYCLES+1 cycles.
- UART requirement: tx_busy asserts within one cycle of the UART sampling wr_uart.
- Data stability: send_data changes after E0 do not affect the frame in flight.
- send while busy=1 is ignored and not queued. send held high through DONE starts a new frame only once back in IDLE.
- wr_uart is never high on two consecutive cycles.
- Counter and index arithmetic is unsigned. The payload index never under- or overflows, for any FRAME_BYTES ≥ 1.

Decomposition:
- Package debug_tx_pkg holds:
  - state encoding constants IDLE/EMIT/HOLD/DONE
  - a function for total byte count from the parameters
  - the default SYNC_BYTE
- One sub-module, debug_frame_sel: a combinational byte selector. It maps counter → header/payload/checksum byte and applies MSB_FIRST. Keeping it separate keeps the wide mux out of the FSM.

Test Plan:
- FRAME_BYTES=4, defaults, send_data=32'h11223344, tx_busy=0 → w_data sequence A5,00,04,11,22,33,44,AA; 8 strobes, 2 cycles apart; done is one pulse after the last HOLD.
- MSB_FIRST=0, SEND_HEADER=0, SEND_CHECKSUM=0, same data → sequence 44,33,22,11, then done; busy is low afterwards.
- Stall: tx_busy held at 1 for 10 cycles before the 3rd byte → no wr_uart during the stall; byte 04 is sent on the first edge with tx_busy=0; the sequence is otherwise unchanged.
- send_data changed to 32'hDEADBEEF and send pulsed mid-frame → the original frame completes unchanged; no second frame starts.
- reset driven low after the 2nd strobe → all outputs are 0 immediately. After reset release and a new send, the full frame restarts from A5.
- FRAME_BYTES=1, data 8'hFF, GAP_CYCLES=3 → sequence A5,00,01,FF,FF; strobes 4 cycles apart.
